// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: the source drives in_*, the consumer drives out_ready.
// master = operand source and result consumer side, slave = the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry;
  logic             a_is_zero;

  modport slave (
    input  in_valid, in_a, in_b, opcode, out_ready,
    output in_ready, out_valid, alu_out, carry, a_is_zero
  );

  modport master (
    output in_valid, in_a, in_b, opcode, out_ready,
    input  in_ready, out_valid, alu_out, carry, a_is_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready in/out, accumulator and optional shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 111 behaves as PASS_A.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_if.slave       io_bus,
  output logic [1:0]     o_dbg_state
);

  // Handshake: an operation is taken when in_valid && in_ready; a result is
  // consumed when out_valid && out_ready. out_valid/alu_out/carry/a_is_zero
  // stay frozen while a result is held and not consumed.

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_PASS_A  = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_AND     = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_PASS_B  = 3'b101;
  localparam logic [2:0] OP_ACC_ADD = 3'b110;
  localparam logic [2:0] OP_MUL     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_deliver;
  logic             w_is_mul;
  logic             w_mul_last;
  logic             w_load_res;
  logic             w_start_mul;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_res;

  logic [WIDTH-1:0] r_alu_out;
  logic             r_carry;
  logic             r_a_is_zero;
  logic [WIDTH-1:0] r_acc;

  assign w_a = io_bus.in_a;
  assign w_b = io_bus.in_b;

  // in_ready looks through to out_ready so a held result can be replaced in the same cycle.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_deliver  = (r_state == S_HOLD) && io_bus.out_ready;

  // Single-cycle datapath in WIDTH+1 bits; the top bit is carry or borrow.
  always_comb begin
    w_res = {1'b0, w_a};
    case (io_bus.opcode)
      OP_PASS_A:  w_res = {1'b0, w_a};
      OP_SUB:     w_res = {1'b0, w_a} - {1'b0, w_b};
      OP_ADD:     w_res = {1'b0, w_a} + {1'b0, w_b};
      OP_AND:     w_res = {1'b0, w_a & w_b};
      OP_XOR:     w_res = {1'b0, w_a ^ w_b};
      OP_PASS_B:  w_res = {1'b0, w_b};
      OP_ACC_ADD: w_res = {1'b0, r_acc} + {1'b0, w_a};
      default:    w_res = {1'b0, w_a};
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_mul_cnt;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_is_mul    = (io_bus.opcode == OP_MUL);
  assign w_mul_last  = (r_state == S_MUL) && (r_mul_cnt == CW'(WIDTH - 1));
  assign w_prod_next = r_mul_b[0] ? (r_prod + r_mul_a) : r_prod;

  // Multiplicand shifts left, multiplier shifts right: one partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_prod    <= '0;
      r_mul_cnt <= '0;
    end else if (w_start_mul) begin
      r_mul_a   <= {{WIDTH{1'b0}}, w_a};
      r_mul_b   <= w_b;
      r_prod    <= '0;
      r_mul_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_prod    <= w_prod_next;
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_mul_cnt <= w_mul_last ? '0 : r_mul_cnt + CW'(1);
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_last = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load_res   = 1'b0;
    w_start_mul  = 1'b0;
    case (r_state)
      S_IDLE, S_HOLD: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_start_mul  = 1'b1;
            w_next_state = S_MUL;
          end else begin
            w_load_res   = 1'b1;
            w_next_state = S_HOLD;
          end
        end else if (w_deliver) begin
          w_next_state = S_IDLE;
        end
      end
      S_MUL: begin
        if (w_mul_last) w_next_state = S_HOLD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out   <= '0;
      r_carry     <= 1'b0;
      r_a_is_zero <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (w_load_res) begin
        r_alu_out <= w_res[WIDTH-1:0];
        r_carry   <= w_res[WIDTH];
      end
`ifdef ALU_MUL_EN
      else if (w_mul_last) begin
        r_alu_out <= w_prod_next[WIDTH-1:0];
        r_carry   <= |w_prod_next[2*WIDTH-1:WIDTH];
      end
`endif
      if (w_accept) r_a_is_zero <= (w_a == '0);
      if (w_load_res && (io_bus.opcode == OP_ACC_ADD)) r_acc <= w_res[WIDTH-1:0];
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_state == S_HOLD);
  assign io_bus.alu_out   = r_alu_out;
  assign io_bus.carry     = r_carry;
  assign io_bus.a_is_zero = r_a_is_zero;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table plus hand-written stall, stream, reset and opcode-111 sequences.
module tb_alu_seq;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus.slave),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       az;
  } vec_t;

  vec_t vecs[11];
  vec_t strm[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operation for one edge; caller guarantees in_ready is high.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (bus.out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int seen;
    logic [W:0] e;

    vecs[0]  = '{"add_basic",  3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[1]  = '{"add_wrap",   3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{"sub_borrow", 3'b001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[3]  = '{"sub_plain",  3'b001, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
    vecs[4]  = '{"pass_a_0",   3'b000, 8'h00, 8'h9C, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{"and",        3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[6]  = '{"xor",        3'b100, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
    vecs[7]  = '{"pass_b",     3'b101, 8'h00, 8'hAB, 8'hAB, 1'b0, 1'b1};
    vecs[8]  = '{"acc_1",      3'b110, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
    vecs[9]  = '{"acc_2",      3'b110, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{"acc_3",      3'b110, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0};

    strm[0] = '{"s_add",  3'b010, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
    strm[1] = '{"s_sub",  3'b001, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    strm[2] = '{"s_addc", 3'b010, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
    strm[3] = '{"s_xor",  3'b100, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};

    // Reset
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_out",   bus.alu_out,   0);
    check("rst_carry",     bus.carry,     0);
    check("rst_a_is_zero", bus.a_is_zero, 0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_state",     dbg_state,     0);

    // Single-op vectors, consumer always ready
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_valid"}, bus.out_valid, 1);
      check({vecs[i].name, "_out"},   bus.alu_out,   vecs[i].res);
      check({vecs[i].name, "_carry"}, bus.carry,     vecs[i].c);
      check({vecs[i].name, "_az"},    bus.a_is_zero, vecs[i].az);
      tick();
      check({vecs[i].name, "_drained"}, bus.out_valid, 0);
    end

    // Reset clears the accumulator
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(3'b110, 8'h03, 8'h00);
    check("acc_after_rst", bus.alu_out, 8'h03);
    check("acc_after_rst_c", bus.carry, 0);
    tick();

    // Back-pressure: hold XOR result for 5 cycles while next op waits
    bus.out_ready = 1'b0;
    send(3'b100, 8'hF0, 8'h3C);
    exp_q.push_back({1'b0, 8'hCC});
    bus.in_valid = 1'b1;
    bus.opcode   = strm[0].op;
    bus.in_a     = strm[0].a;
    bus.in_b     = strm[0].b;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid",    bus.out_valid, 1);
      check("stall_out",      bus.alu_out,   8'hCC);
      check("stall_carry",    bus.carry,     0);
      check("stall_in_ready", bus.in_ready,  0);
      tick();
    end

    // Stream 4 ops back-to-back, one delivery per cycle in order
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = strm[i].op;
      bus.in_a     = strm[i].a;
      bus.in_b     = strm[i].b;
      exp_q.push_back({strm[i].c, strm[i].res});
      #1;
      check("stream_in_ready", bus.in_ready,  1);
      check("stream_valid",    bus.out_valid, 1);
      e = exp_q.pop_front();
      check("stream_result", {bus.carry, bus.alu_out}, e);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    check("stream_last_valid", bus.out_valid, 1);
    e = exp_q.pop_front();
    check("stream_last_result", {bus.carry, bus.alu_out}, e);
    tick();
    check("stream_drained", bus.out_valid, 0);
    check("stream_queue_empty", exp_q.size(), 0);

    // Reset while holding an undelivered result
    bus.out_ready = 1'b0;
    send(3'b101, 8'h00, 8'h77);
    check("hold_valid", bus.out_valid, 1);
    check("hold_out",   bus.alu_out,   8'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hold_rst_valid",    bus.out_valid, 0);
    check("hold_rst_out",      bus.alu_out,   0);
    check("hold_rst_in_ready", bus.in_ready,  1);
    bus.out_ready = 1'b1;

`ifdef ALU_MUL_EN
    // MUL 0x0F*0x11, operand lines disturbed mid-operation
    send(3'b111, 8'h0F, 8'h11);
    bus.in_a = 8'hFF;
    bus.in_b = 8'hFF;
    check("mul_in_ready_busy", bus.in_ready, 0);
    wait_valid(cyc);
    check("mul1_latency", cyc, 9);
    check("mul1_out",     bus.alu_out, 8'hFF);
    check("mul1_carry",   bus.carry,   0);
    check("mul1_az",      bus.a_is_zero, 0);
    tick();

    send(3'b111, 8'h10, 8'h10);
    wait_valid(cyc);
    check("mul2_latency", cyc, 9);
    check("mul2_out",     bus.alu_out, 8'h00);
    check("mul2_carry",   bus.carry,   1);
    tick();

    // Reset during cycle 4 of a multiply drops it
    send(3'b111, 8'h03, 8'h05);
    repeat (3) tick();
    check("mul_mid_state", dbg_state, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mul_rst_state",    dbg_state,     0);
    check("mul_rst_valid",    bus.out_valid, 0);
    check("mul_rst_in_ready", bus.in_ready,  1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    check("mul_rst_no_result", seen, 0);
`else
    // Opcode 111 without the multiplier is single-cycle PASS_A
    send(3'b111, 8'h5A, 8'h33);
    check("op7_valid", bus.out_valid, 1);
    check("op7_out",   bus.alu_out,   8'h5A);
    check("op7_carry", bus.carry,     0);
    tick();
    check("op7_drained", bus.out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
